// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, midpoint sampling, LSB-first 8-bit frames.
// Optional parity bit after the data bits when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int PARITY_ODD   = 0
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Framing_Err,
  output logic       o_Rx_Parity_Err
);

  localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_COUNT = 16'((CLKS_PER_BIT - 1) / 2);

  generate
    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
      $error("uart_rx: CLKS_PER_BIT must be 4..65535 and PARITY_ODD 0 or 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    CLEANUP
  } state_t;

  state_t      state;
  logic        rx_meta;
  logic        rx;
  logic        rx_d;
  logic [15:0] clock_count;
  logic [2:0]  bit_index;
  logic [7:0]  shift;

`ifdef UART_RX_PARITY_EN
  localparam logic PARITY_SENSE = (PARITY_ODD != 0);
  logic parity_bad;
  logic parity_err;
  assign o_Rx_Parity_Err = parity_err;
`else
  assign o_Rx_Parity_Err = 1'b0;
`endif

  // Line reset to idle-high so the first cycle after reset cannot look like a start edge.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop see the previous stage's old value.
      rx_meta <= i_Rx_Serial;
      rx      <= rx_meta;
      rx_d    <= rx;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state            <= IDLE;
      clock_count      <= '0;
      bit_index        <= '0;
      shift            <= '0;
      o_Rx_DV          <= 1'b0;
      o_Rx_Byte        <= 8'h00;
      o_Rx_Active      <= 1'b0;
      o_Rx_Framing_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad       <= 1'b0;
      parity_err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          clock_count <= '0;
          bit_index   <= '0;
          if (!rx && rx_d) begin
            state       <= START;
            o_Rx_Active <= 1'b1;
          end
        end

        START: begin
          if (clock_count == HALF_COUNT) begin
            clock_count <= '0;
            bit_index   <= '0;
            if (!rx) begin
              state <= DATA;
            end else begin
              state       <= IDLE;
              o_Rx_Active <= 1'b0;
            end
          end else begin
            clock_count <= clock_count + 16'd1;
          end
        end

        DATA: begin
          if (clock_count == LAST_COUNT) begin
            clock_count      <= '0;
            shift[bit_index] <= rx;
            if (bit_index == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_index <= bit_index + 3'd1;
            end
          end else begin
            clock_count <= clock_count + 16'd1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (clock_count == LAST_COUNT) begin
            clock_count <= '0;
            parity_bad  <= (rx != ((^shift) ^ PARITY_SENSE));
            state       <= STOP;
          end else begin
            clock_count <= clock_count + 16'd1;
          end
        end
`endif

        STOP: begin
          if (clock_count == LAST_COUNT) begin
            clock_count <= '0;
            state       <= CLEANUP;
            if (rx) begin
              o_Rx_Byte <= shift;
              o_Rx_DV   <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err <= parity_bad;
`endif
            end else begin
              o_Rx_Framing_Err <= 1'b1;
            end
          end else begin
            clock_count <= clock_count + 16'd1;
          end
        end

        CLEANUP: begin
          o_Rx_DV          <= 1'b0;
          o_Rx_Framing_Err <= 1'b0;
          o_Rx_Active      <= 1'b0;
`ifdef UART_RX_PARITY_EN
          parity_err       <= 1'b0;
`endif
          state            <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive side of the I2C-to-UART bridge: deserialises an asynchronous 8N1 stream into bytes for the bridge core.
- Format: LSB first, one start bit, one stop bit, optional parity.
- Same clock domain and CLKS_PER_BIT convention as the UART transmitter: CLKS_PER_BIT = f(i_Clock) / baud.
- Oversamples the line with a bit-period counter and samples each bit at its midpoint.

Parameters:
- CLKS_PER_BIT, 87: clocks per bit (10 MHz / 115200). Legal range 4..65535.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Used only when UART_RX_PARITY_EN is defined.

Ports:
- i_Clock  input  1  system clock, rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Rx_Serial  input  1  asynchronous serial line; idles high.
- o_Rx_DV  output  1  one-cycle pulse: o_Rx_Byte holds a new, correctly framed byte.
- o_Rx_Byte  output  8  last good byte received; held between pulses.
- o_Rx_Active  output  1  high while a frame is being received.
- o_Rx_Framing_Err  output  1  one-cycle pulse: stop bit sampled low.
- o_Rx_Parity_Err  output  1  one-cycle pulse: parity mismatch. Constant 0 when the parity feature is compiled out.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-high on i_Reset; the clock port is i_Clock.
  - Reset forces: state IDLE, all counters 0, synchroniser flops and r_Rx_d to 1.
  - Reset values: o_Rx_DV=0, o_Rx_Byte=8'h00, o_Rx_Active=0, o_Rx_Framing_Err=0, o_Rx_Parity_Err=0.
  - Reset mid-frame abandons the frame silently; no error pulse.
- Input conditioning:
  - i_Rx_Serial passes through a 2-flop synchroniser, giving r_Rx.
  - r_Rx_d is r_Rx delayed by one register.
  - A start is a falling edge: r_Rx=0 and r_Rx_d=1.
- Counters:
  - Clock counter r_Clock_Count is 16 bits.
  - Bit index is 3 bits.
  - H = (CLKS_PER_BIT-1)/2, integer division.
- State IDLE:
  - On a falling edge: go to START, count=0, o_Rx_Active=1.
  - A line held low with no falling edge does not start a frame.
- State START:
  - Increment count until count==H.
  - At count==H: if r_Rx=0, go to DATA with count=0 and index=0.
  - At count==H with r_Rx=1: false start (glitch); go to IDLE, o_Rx_Active=0, no pulses.
- State DATA:
  - Increment count until count==CLKS_PER_BIT-1.
  - At count==CLKS_PER_BIT-1: shift r_Rx into shift register bit [index]; count=0.
  - If index<7, increment index. At index 7, go to PARITY if the feature is enabled, else to STOP.
- State PARITY (feature only):
  - Same counting as DATA; samples one bit at count==CLKS_PER_BIT-1, then goes to STOP.
- State STOP:
  - At count==CLKS_PER_BIT-1, sample r_Rx:
    - r_Rx=1: o_Rx_Byte<=shift register, o_Rx_DV<=1.
    - r_Rx=0: o_Rx_Framing_Err<=1. o_Rx_DV stays 0 and o_Rx_Byte is unchanged.
  - Then go to CLEANUP.
- State CLEANUP:
  - One cycle; clears all pulse outputs, sets o_Rx_Active=0, goes to IDLE.
  - Every pulse is therefore exactly one cycle wide.
- Latency:
  - Count the first rising edge at which i_Rx_Serial is low as edge 1.
  - The STOP sample occurs at edge 4+H+9*CLKS_PER_BIT, plus CLKS_PER_BIT with parity.
  - o_Rx_DV is high in the cycle after that edge.
- Back-to-back frames:
  - A next start edge arriving during STOP or CLEANUP is missed. The transmitter always meets this, since it sends a full stop bit.
  - A start edge arriving after CLEANUP is accepted; no idle gap is required.
- Break (line stuck low): exactly one framing-error pulse, then IDLE waits for the line to return high and fall again.
- Error precedence: framing error suppresses o_Rx_DV and o_Rx_Parity_Err.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds the PARITY state after DATA.
  - Expected bit = XOR of the data bits, XOR PARITY_ODD.
  - On mismatch with a good stop bit: o_Rx_DV=1 and o_Rx_Parity_Err=1 in the same cycle, and the byte is still delivered.
- Undefined:
  - No PARITY state; frame is 8N1.
  - o_Rx_Parity_Err is tied to 0 and PARITY_ODD is ignored.

Test Plan:
- CLKS_PER_BIT=8 (H=3), send 8'hA5 as 8N1 -> o_Rx_DV high for exactly 1 cycle at the cycle after edge 79; o_Rx_Byte=8'hA5; no error pulses; o_Rx_Active low afterwards.
- Back-to-back 8'h00, 8'hFF, 8'h3C with zero idle between stop and next start -> three DV pulses, bytes in order, no errors.
- Low glitch of 2 clocks on an idle line -> no DV, no error; o_Rx_Active pulses and returns to 0 by edge 4+H.
- Send 8'h5A with the stop bit driven 0 -> o_Rx_Framing_Err 1-cycle pulse, no DV, o_Rx_Byte keeps its previous value.
- Line held low for 30 bit periods, then high, then 8'h81 sent -> exactly one framing-error pulse, then DV with 8'h81.
- Reset asserted mid DATA of 8'hC3, released, then 8'h42 sent -> no pulse from the aborted frame, all outputs at reset values; next DV carries 8'h42. With UART_RX_PARITY_EN, PARITY_ODD=0: 8'h07 sent with parity bit 0 -> DV and o_Rx_Parity_Err together, byte 8'h07.
